// File: rtl/gnt_issue_buffer_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
//   Shared defaults and packet types for the grant-driven issue buffer.
//   The struct types are sized from the package defaults. A build that
//   overrides WIDTH or TAG_W on the buffer must also change these localparams
//   so that the struct fields and the port slices stay the same width.
// -----------------------------------------------------------------------------
package issue_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_REQS  = 2;
  localparam int DEF_TAG_W = 6;
  localparam int DEF_IDX_W = $clog2(DEF_WIDTH);

  // One registered issue lane: strobe, slot index and the slot's tag.
  typedef struct packed {
    logic                 valid;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_TAG_W-1:0] tag;
  } issue_pkt_t;

  // Read view of one entry slot.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } slot_t;

endpackage : issue_pkg

// File: rtl/gnt_issue_buffer_if.sv
// -----------------------------------------------------------------------------
// gnt_issue_buffer_if
//   Bundles the dispatch-side allocation, the selector-side req/gnt exchange
//   and the issue outputs of gnt_issue_buffer.
//   slave  : used by the buffer (consumes alloc/gnt/flush, drives the rest)
//   master : used by the environment (dispatch + selector + issue consumer)
// -----------------------------------------------------------------------------
interface gnt_issue_buffer_if
  import issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REQS  = DEF_REQS,
  parameter int TAG_W = DEF_TAG_W
);
  localparam int IDX_W = $clog2(WIDTH);

  logic                     flush;
  logic [REQS-1:0]          alloc_valid;
  logic [REQS*TAG_W-1:0]    alloc_tag;
  logic                     alloc_ready;
  logic [WIDTH-1:0]         req;
  logic [WIDTH*REQS-1:0]    gnt_bus;
  logic [REQS-1:0]          issue_valid;
  logic [REQS*IDX_W-1:0]    issue_idx;
  logic [REQS*TAG_W-1:0]    issue_tag;
  logic [IDX_W:0]           free_count;
  logic                     proto_err;

  modport slave (
    input  flush, alloc_valid, alloc_tag, gnt_bus,
    output alloc_ready, req, issue_valid, issue_idx, issue_tag,
           free_count, proto_err
  );

  modport master (
    output flush, alloc_valid, alloc_tag, gnt_bus,
    input  alloc_ready, req, issue_valid, issue_idx, issue_tag,
           free_count, proto_err
  );

endinterface : gnt_issue_buffer_if

// File: rtl/gnt_issue_buffer_onehot_enc.sv
// -----------------------------------------------------------------------------
// onehot_enc
//   Encodes one grant lane. For a one-hot input, idx is the set bit's position.
//   nonzero flags any set bit; multi_hot flags two or more set bits (idx is
//   then meaningless and the caller must ignore it).
//   Ports: onehot (in, WIDTH), idx (out, IDX_W), nonzero (out), multi_hot (out)
// -----------------------------------------------------------------------------
module onehot_enc #(
  parameter int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             nonzero,
  output logic             multi_hot
);

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

  assign nonzero   = |onehot;
  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi_hot = |(onehot & (onehot - WIDTH'(1)));

endmodule : onehot_enc

// File: rtl/gnt_issue_buffer.sv
// -----------------------------------------------------------------------------
// gnt_issue_buffer
//   Requester-side partner of a combinational priority selector. Holds up to
//   WIDTH pending entries, presents their valid bits as req, turns each legal
//   grant lane into a registered issue packet one cycle later, frees the
//   granted slots and refills free slots from up to REQS allocs per cycle.
//   Ports:
//     clock   : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : gnt_issue_buffer_if.slave
//               flush, alloc_valid/alloc_tag/alloc_ready, req, gnt_bus,
//               issue_valid/issue_idx/issue_tag, free_count, proto_err
// -----------------------------------------------------------------------------
module gnt_issue_buffer
  import issue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REQS  = DEF_REQS,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic               clock,
  input  logic               reset_n,
  gnt_issue_buffer_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [WIDTH];
  logic [CNT_W-1:0] free_q;
  logic             err_q;
  issue_pkt_t       issue_q [REQS];

  slot_t            slot_rd [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_slot_view
    assign slot_rd[i] = '{valid: valid_q[i], tag: tag_q[i]};
  end

  // ---------------------------------------------------------------------------
  // Grant lanes: slice, encode, qualify
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] lane       [REQS];
  logic [IDX_W-1:0] lane_idx   [REQS];
  logic [REQS-1:0]  lane_nz;
  logic [REQS-1:0]  lane_multi;

  for (genvar j = 0; j < REQS; j++) begin : g_lane
    assign lane[j] = bus.gnt_bus[(j+1)*WIDTH-1 -: WIDTH];

    onehot_enc #(.WIDTH(WIDTH)) u_enc (
      .onehot    (lane[j]),
      .idx       (lane_idx[j]),
      .nonzero   (lane_nz[j]),
      .multi_hot (lane_multi[j])
    );
  end

  logic [REQS-1:0]  gnt_ok;     // lane issues and frees its slot
  logic [WIDTH-1:0] clr_mask;   // slots freed this cycle
  logic             gnt_err;    // any protocol violation this cycle

  always_comb begin
    logic [WIDTH-1:0] lower;    // bits granted by lower-numbered lanes
    gnt_ok   = '0;
    clr_mask = '0;
    gnt_err  = 1'b0;
    lower    = '0;
    for (int j = 0; j < REQS; j++) begin
      if (lane_nz[j]) begin
        if (lane_multi[j]) begin
          gnt_err = 1'b1;
        end else if (!valid_q[lane_idx[j]]) begin
          gnt_err = 1'b1;
        end else if (|(lane[j] & lower)) begin
          // Duplicate of a lower lane: only the lowest lane may issue.
          gnt_err = 1'b1;
        end else begin
          gnt_ok[j] = 1'b1;
          clr_mask  = clr_mask | lane[j];
        end
      end
      lower = lower | lane[j];
    end
  end

  // ---------------------------------------------------------------------------
  // Allocation: pack asserted ports, in port order, into the lowest free slots.
  // Free slots come from registered valid bits only, so a slot freed by a
  // grant this cycle is never re-targeted until the next one.
  // ---------------------------------------------------------------------------
  logic             alloc_ready;
  logic [REQS-1:0]  alloc_en;
  logic [WIDTH-1:0] free_mask [REQS+1];
  logic [WIDTH-1:0] pick      [REQS];
  logic [WIDTH-1:0] set_mask;

  assign alloc_ready  = (free_q >= CNT_W'(REQS));
  assign free_mask[0] = ~valid_q;

  for (genvar j = 0; j < REQS; j++) begin : g_pick
    // x & -x isolates the lowest set bit of the remaining free mask.
    assign pick[j]        = free_mask[j] & (~free_mask[j] + WIDTH'(1));
    assign free_mask[j+1] = bus.alloc_valid[j] ? (free_mask[j] & ~pick[j])
                                               : free_mask[j];
    assign alloc_en[j]    = alloc_ready & ~bus.flush & bus.alloc_valid[j];
  end

  logic [CNT_W-1:0] alloc_cnt;
  logic [CNT_W-1:0] gnt_cnt;
  logic [CNT_W-1:0] free_nxt;

  always_comb begin
    set_mask  = '0;
    alloc_cnt = '0;
    gnt_cnt   = '0;
    for (int j = 0; j < REQS; j++) begin
      if (alloc_en[j]) begin
        set_mask  = set_mask | pick[j];
        alloc_cnt = alloc_cnt + CNT_W'(1);
      end
      if (gnt_ok[j]) gnt_cnt = gnt_cnt + CNT_W'(1);
    end
    free_nxt = free_q - alloc_cnt + gnt_cnt;
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      valid_q <= '0;
      free_q  <= CNT_W'(WIDTH);
      err_q   <= 1'b0;
      for (int j = 0; j < REQS; j++) issue_q[j] <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      free_q  <= CNT_W'(WIDTH);
      for (int j = 0; j < REQS; j++) issue_q[j] <= '0;
    end else begin
      valid_q <= (valid_q & ~clr_mask) | set_mask;
      free_q  <= free_nxt;
      err_q   <= err_q | gnt_err;
      for (int j = 0; j < REQS; j++) begin
        issue_q[j].valid <= gnt_ok[j];
        if (gnt_ok[j]) begin
          issue_q[j].idx <= lane_idx[j];
          issue_q[j].tag <= slot_rd[lane_idx[j]].tag;
        end
      end
    end
  end

  // NOTE: tag storage has no reset; a tag is only ever read behind its valid bit.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < REQS; j++) begin
        if (alloc_en[j] && pick[j][i]) tag_q[i] <= bus.alloc_tag[(j+1)*TAG_W-1 -: TAG_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req         = valid_q;
  assign bus.alloc_ready = alloc_ready;
  assign bus.free_count  = free_q;
  assign bus.proto_err   = err_q;

  for (genvar j = 0; j < REQS; j++) begin : g_out
    assign bus.issue_valid[j]                    = issue_q[j].valid;
    assign bus.issue_idx[(j+1)*IDX_W-1 -: IDX_W] = issue_q[j].idx;
    assign bus.issue_tag[(j+1)*TAG_W-1 -: TAG_W] = issue_q[j].tag;
  end

endmodule : gnt_issue_buffer

// File: tb/tb_gnt_issue_buffer.sv
// -----------------------------------------------------------------------------
// tb_gnt_issue_buffer
//   Directed bench for gnt_issue_buffer (WIDTH=16, REQS=2, TAG_W=6). Inputs
//   change 1 time unit after a rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_gnt_issue_buffer;

  logic clock;
  logic reset_n;

  int check_count = 0;
  int pass_count  = 0;

  gnt_issue_buffer_if #(.WIDTH(16), .REQS(2), .TAG_W(6)) bus ();

  gnt_issue_buffer #(.WIDTH(16), .REQS(2), .TAG_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] observed,
                       input logic [63:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
  endtask

  task automatic drive(input logic fl, input logic [1:0] av,
                       input logic [5:0] t0, input logic [5:0] t1,
                       input logic [15:0] g0, input logic [15:0] g1);
    bus.flush       = fl;
    bus.alloc_valid = av;
    bus.alloc_tag   = {t1, t0};
    bus.gnt_bus     = {g1, g0};
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;

    // 1. Reset state
    check("rst_req",        bus.req,         16'h0000);
    check("rst_free",       bus.free_count,  5'd16);
    check("rst_ready",      bus.alloc_ready, 1'b1);
    check("rst_issue_v",    bus.issue_valid, 2'b00);
    check("rst_issue_idx",  bus.issue_idx,   8'h00);
    check("rst_issue_tag",  bus.issue_tag,   12'h000);
    check("rst_perr",       bus.proto_err,   1'b0);
    reset_n = 1'b1;

    // 2. Dual alloc into empty buffer: slots 0,1
    drive(1'b0, 2'b11, 6'h05, 6'h0A, 16'h0000, 16'h0000);
    tick(); idle();
    check("alloc2_req",  bus.req,        16'h0003);
    check("alloc2_free", bus.free_count, 5'd14);

    // 3. Grant both; issue one cycle later with stored tags
    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0001, 16'h0002);
    tick(); idle();
    check("gnt2_issue_v",   bus.issue_valid, 2'b11);
    check("gnt2_issue_idx", bus.issue_idx,   {4'd1, 4'd0});
    check("gnt2_issue_tag", bus.issue_tag,   {6'h0A, 6'h05});
    check("gnt2_req",       bus.req,         16'h0000);
    check("gnt2_free",      bus.free_count,  5'd16);
    tick();
    check("zero_lane_issue_v", bus.issue_valid, 2'b00);

    // 4. Fill: slot k gets tag k
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 2'b11, 6'(2*c), 6'(2*c+1), 16'h0000, 16'h0000);
      tick();
    end
    idle();
    check("full_free",  bus.free_count,  5'd0);
    check("full_ready", bus.alloc_ready, 1'b0);
    check("full_req",   bus.req,         16'hFFFF);

    drive(1'b0, 2'b11, 6'h3F, 6'h3F, 16'h0008, 16'h0000);
    tick(); idle();
    check("full_gnt_free",    bus.free_count,      5'd1);
    check("full_gnt_req",     bus.req,             16'hFFF7);
    check("full_gnt_issue_v", bus.issue_valid,     2'b01);
    check("full_gnt_idx0",    bus.issue_idx[3:0],  4'd3);
    check("full_gnt_tag0",    bus.issue_tag[5:0],  6'h03);
    check("one_free_ready",   bus.alloc_ready,     1'b0);

    drive(1'b0, 2'b01, 6'h3E, 6'h00, 16'h0000, 16'h0000);
    tick(); idle();
    check("ignored_alloc_free", bus.free_count, 5'd1);
    check("ignored_alloc_req",  bus.req,        16'hFFF7);

    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0000, 16'h0020);
    tick(); idle();
    check("lane1_free",    bus.free_count,      5'd2);
    check("lane1_req",     bus.req,             16'hFFD7);
    check("lane1_issue_v", bus.issue_valid,     2'b10);
    check("lane1_idx1",    bus.issue_idx[7:4],  4'd5);
    check("lane1_tag1",    bus.issue_tag[11:6], 6'h05);
    check("two_free_ready", bus.alloc_ready,    1'b1);

    drive(1'b0, 2'b11, 6'h3A, 6'h3B, 16'h0000, 16'h0000);
    tick(); idle();
    check("refill_req",  bus.req,        16'hFFFF);
    check("refill_free", bus.free_count, 5'd0);

    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0008, 16'h0020);
    tick(); idle();
    check("refill_issue_v",   bus.issue_valid, 2'b11);
    check("refill_issue_idx", bus.issue_idx,   {4'd5, 4'd3});
    check("refill_issue_tag", bus.issue_tag,   {6'h3B, 6'h3A});
    check("refill_free2",     bus.free_count,  5'd2);
    check("no_err_yet",       bus.proto_err,   1'b0);

    // 5. Protocol errors
    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h8000, 16'h0000);
    tick(); idle();
    check("slot15_issue_v", bus.issue_valid,    2'b01);
    check("slot15_idx0",    bus.issue_idx[3:0], 4'd15);
    check("slot15_tag0",    bus.issue_tag[5:0], 6'h0F);
    check("slot15_req",     bus.req,            16'h7FD7);

    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h8000, 16'h0000);
    tick(); idle();
    check("inv_issue_v", bus.issue_valid, 2'b00);
    check("inv_perr",    bus.proto_err,   1'b1);
    check("inv_free",    bus.free_count,  5'd3);

    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0004, 16'h0004);
    tick(); idle();
    check("dup_issue_v", bus.issue_valid,    2'b01);
    check("dup_idx0",    bus.issue_idx[3:0], 4'd2);
    check("dup_req",     bus.req,            16'h7FD3);
    check("dup_free",    bus.free_count,     5'd4);
    tick();
    check("perr_sticky", bus.proto_err, 1'b1);

    // 6. Down to 10 occupied, then flush with alloc and grant pending
    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0001, 16'h0002);
    tick(); idle();
    check("ten_req",  bus.req,        16'h7FD0);
    check("ten_free", bus.free_count, 5'd6);

    drive(1'b1, 2'b11, 6'h11, 6'h22, 16'h0010, 16'h0000);
    tick(); idle();
    check("flush_req",     bus.req,         16'h0000);
    check("flush_free",    bus.free_count,  5'd16);
    check("flush_issue_v", bus.issue_valid, 2'b00);
    check("flush_perr",    bus.proto_err,   1'b1);

    drive(1'b0, 2'b11, 6'h01, 6'h02, 16'h0000, 16'h0000);
    tick(); idle();
    check("post_flush_req", bus.req, 16'h0003);
    drive(1'b0, 2'b00, 6'h00, 6'h00, 16'h0001, 16'h0000);
    tick(); idle();
    check("pre_rst_issue_v", bus.issue_valid, 2'b01);
    check("pre_rst_free",    bus.free_count,  5'd15);

    // Asynchronous reset mid-cycle, sampled before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("arst_req",       bus.req,         16'h0000);
    check("arst_free",      bus.free_count,  5'd16);
    check("arst_issue_v",   bus.issue_valid, 2'b00);
    check("arst_issue_idx", bus.issue_idx,   8'h00);
    check("arst_issue_tag", bus.issue_tag,   12'h000);
    check("arst_perr",      bus.proto_err,   1'b0);
    check("arst_ready",     bus.alloc_ready, 1'b1);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_gnt_issue_buffer

// File: doc/gnt_issue_buffer.md
Name: gnt_issue_buffer

Overview:
- Requester-side partner of the parametrizable priority selector. Holds up to WIDTH pending entries and drives the `req` vector.
- Consumes the per-lane one-hot `gnt_bus` returned by the selector and turns each granted lane into a registered issue packet (slot index plus tag).
- Frees granted slots and refills them from up to REQS allocations per cycle.
- Sits between dispatch and the select logic of an issue stage.

Parameters:
- WIDTH, 16, number of entry slots; equals the selector's request width.
- REQS, 2, number of grant lanes and of alloc ports; equals the selector's grant count.
- TAG_W, 6, payload tag width per entry.
- IDX_W, $clog2(WIDTH), slot index width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- alloc_valid  in  REQS  per-port allocation request.
- alloc_tag  in  REQS*TAG_W  per-port tag; port j at [(j+1)*TAG_W-1 -: TAG_W].
- alloc_ready  out  1  high when free_count >= REQS; combinational from state.
- req  out  WIDTH  valid bits of occupied slots; driven to the selector.
- gnt_bus  in  WIDTH*REQS  one-hot (or zero) grant per lane; lane j at [(j+1)*WIDTH-1 -: WIDTH].
- issue_valid  out  REQS  registered per-lane issue strobe.
- issue_idx  out  REQS*IDX_W  registered slot index per lane.
- issue_tag  out  REQS*TAG_W  registered tag per lane.
- free_count  out  IDX_W+1  number of empty slots; registered state.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All slot valid bits = 0, so req = 0.
  - issue_valid = 0, issue_idx = 0, issue_tag = 0.
  - free_count = WIDTH; proto_err = 0.
- req equals the registered valid vector. The selector is combinational, so `gnt_bus` is sampled in the same cycle as `req`.
- Grant handling (each edge, per lane j):
  - If lane j is nonzero, encode its one-hot to an index.
  - Next cycle: issue_valid[j] = 1, issue_idx[j] = that index, issue_tag[j] = the tag stored in that slot.
  - The slot's valid bit clears at the same edge.
  - Issue latency is 1 cycle from grant. A zero lane gives issue_valid[j] = 0 next cycle.
- Protocol errors: proto_err sets and stays set until reset if any of the following occurs.
  - A lane is non-one-hot and nonzero.
  - A lane grants a slot whose valid bit is 0.
  - Two lanes grant the same bit.
- Handling of a grant that raised proto_err:
  - A grant to an invalid slot is dropped: issue_valid[j] = 0.
  - A duplicate grant issues only on the lowest lane.
  - A multi-hot lane issues nothing.
- Allocation:
  - Accepted only when alloc_ready = 1. Requests arriving with alloc_ready = 0 are ignored with no partial acceptance.
  - Asserted alloc ports are packed in port order into free slots, lowest index first: the lowest-numbered asserted port takes the lowest free slot, and so on.
  - Free slots are computed from registered state only. A slot freed by a grant in cycle N is allocatable from cycle N+1.
  - Because of this rule, alloc and grant never target the same slot in one cycle.
- free_count(next) = free_count − accepted_allocs + valid_grants. The value always stays within 0..WIDTH.
- flush:
  - Highest priority. Next cycle all valid bits = 0, issue_valid = 0, and free_count = WIDTH.
  - Grants and allocs in the flush cycle are discarded. proto_err is unaffected.
- Full state (free_count < REQS): alloc_ready = 0. Grants still drain normally.
- Empty state: req = 0, and grants are expected to be zero. Any nonzero grant is a protocol error.
- Simultaneous events: alloc on REQS ports while REQS grants occur leaves free_count unchanged.

Decomposition:
- Shared package `issue_pkg`:
  - Default WIDTH, REQS and TAG_W localparams.
  - Typedef `issue_pkt_t` {valid, idx, tag}.
  - Typedef `slot_t` {valid, tag}.
- One sub-module, `onehot_enc`:
  - Parameter WIDTH.
  - Inputs: one-hot vector. Outputs: index, nonzero flag, multi-hot flag.
  - Instantiated once per lane.
- The lowest-first free-slot picker is inline generate logic: an iterative mask over ~valid, REQS deep.

Test Plan:
1. Reset → req = 16'h0000, free_count = 16, alloc_ready = 1, issue_valid = 2'b00, proto_err = 0.
2. Empty buffer; alloc_valid = 2'b11 with tags 6'h05 and 6'h0A → next cycle req = 16'h0003, free_count = 14, slot0 tag = 05, slot1 tag = 0A.
3. Continuing from scenario 2, the grant cycle: lane0 = 16'h0001, lane1 = 16'h0002.
   - Next cycle: issue_valid = 2'b11, idx {0, 1}, tags {05, 0A}.
   - Also next cycle: req = 16'h0000, free_count = 16.
4. Fill the buffer (8 cycles of dual alloc) → free_count = 0, alloc_ready = 0.
   - Then in one cycle, grant lane0 = slot 3 and alloc_valid = 2'b11 → alloc ignored, free_count = 1.
   - Next cycle alloc_ready = 0; with alloc_valid = 2'b01 still ignored; slot 3 reused only after another free.
5. Lane0 grants an invalid slot (16'h8000 with slot 15 empty) → issue_valid[0] = 0 next cycle, proto_err = 1 and stays set.
   - Same outcome for lane0 = lane1 = 16'h0004 (duplicate grant): lane0 issues, lane1 does not, proto_err = 1.
6. 10 slots occupied; assert flush together with an alloc and a grant → next cycle req = 0, free_count = 16, issue_valid = 0.
   - Then reset_n pulsed low mid-operation → all outputs return to reset values immediately, without waiting for a clock edge.
